// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths and helpers for the gshare branch-resolution slice.
// The IDX/HIST widths track the predictor's HASH/BHT widths so both sides stay in step.
package branch_resolve_unit_pkg;

  localparam int HASH_WIDTH     = 8;
  localparam int BHT_WIDTH      = 8;
  localparam int BRU_IDX_WIDTH  = HASH_WIDTH;
  localparam int BRU_HIST_WIDTH = BHT_WIDTH;
  localparam int BRU_PC_WIDTH   = 64;
  localparam int PC_INC         = 4;
  localparam int CNT_WIDTH      = 32;

  typedef logic [CNT_WIDTH-1:0] stat_cnt_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
    return (v == '1) ? v : v + stat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/predict and execute-side bundle of the branch resolve unit.
// The master modport is the pipeline side and the slave modport is the resolve unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_WIDTH   = BRU_PC_WIDTH,
  parameter int IDX_WIDTH  = BRU_IDX_WIDTH,
  parameter int HIST_WIDTH = BRU_HIST_WIDTH
) ();

  logic                  pred_valid;
  logic                  pred_ready;
  logic [PC_WIDTH-1:0]   pred_pc;
  logic                  pred_taken;
  logic [PC_WIDTH-1:0]   pred_target;
  logic [IDX_WIDTH-1:0]  pred_idx;
  logic [HIST_WIDTH-1:0] pred_hist;

  logic                  res_valid;
  logic                  res_taken;
  logic [PC_WIDTH-1:0]   res_target;

  logic                  upd_valid;
  logic [IDX_WIDTH-1:0]  upd_idx;
  logic                  upd_taken;
  logic [HIST_WIDTH-1:0] upd_hist;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  res_error;
  stat_cnt_t             branch_cnt;
  stat_cnt_t             miss_cnt;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, pred_idx, pred_hist,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_idx, upd_taken, upd_hist,
    input  redirect_valid, redirect_pc, res_error, branch_cnt, miss_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_idx, pred_hist,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_idx, upd_taken, upd_hist,
    output redirect_valid, redirect_pc, res_error, branch_cnt, miss_cnt
  );

endinterface

// File: rtl/brq_fifo.sv
// Circular in-order queue of in-flight branch predictions with a whole-queue flush.
// The head entry is visible combinationally; a flush wins over a push in the same cycle.
module brq_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[head];

  // NOTE: the storage array has no reset; head/tail/count alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-stage outcomes against buffered gshare predictions, trains the
// predictor, redirects fetch on mispredict and keeps saturating branch statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = BRU_PC_WIDTH,
  parameter int IDX_WIDTH  = BRU_IDX_WIDTH,
  parameter int HIST_WIDTH = BRU_HIST_WIDTH
) (
  input logic                  clock,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * PC_WIDTH + 1 + IDX_WIDTH + HIST_WIDTH;

  logic [ENTRY_W-1:0]    push_data;
  logic [ENTRY_W-1:0]    pop_data;
  logic                  empty;
  logic [PTR_W:0]        count;
  logic                  push;
  logic                  pop;
  logic                  mispredict;
  logic [PC_WIDTH-1:0]   correct_pc;

  logic [PC_WIDTH-1:0]   e_pc;
  logic                  e_taken;
  logic [PC_WIDTH-1:0]   e_target;
  logic [IDX_WIDTH-1:0]  e_idx;
  logic [HIST_WIDTH-1:0] e_hist;

  stat_cnt_t             branch_cnt_q;
  stat_cnt_t             miss_cnt_q;

  assign bus.pred_ready = (count != (PTR_W+1)'(DEPTH));
  assign push           = bus.pred_valid && bus.pred_ready;
  assign pop            = bus.res_valid && !empty;
  assign push_data      = {bus.pred_pc, bus.pred_taken, bus.pred_target, bus.pred_idx, bus.pred_hist};
  assign {e_pc, e_taken, e_target, e_idx, e_hist} = pop_data;

  // A taken branch is also wrong when it went somewhere other than the predicted target.
  assign mispredict = (bus.res_taken != e_taken) || (bus.res_taken && (bus.res_target != e_target));
  assign correct_pc = bus.res_taken ? bus.res_target : e_pc + PC_WIDTH'(PC_INC);

  brq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (pop && mispredict),
    .pop_data  (pop_data),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.upd_valid      <= 1'b0;
      bus.upd_idx        <= '0;
      bus.upd_taken      <= 1'b0;
      bus.upd_hist       <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.res_error      <= 1'b0;
      branch_cnt_q       <= '0;
      miss_cnt_q         <= '0;
    end else begin
      bus.upd_valid      <= pop;
      bus.redirect_valid <= pop && mispredict;
      bus.res_error      <= bus.res_valid && empty;
      if (pop) begin
        bus.upd_idx   <= e_idx;
        bus.upd_taken <= bus.res_taken;
        bus.upd_hist  <= {e_hist[HIST_WIDTH-2:0], bus.res_taken};
        branch_cnt_q  <= sat_inc(branch_cnt_q);
        if (mispredict) begin
          bus.redirect_pc <= correct_pc;
          miss_cnt_q      <= sat_inc(miss_cnt_q);
        end
      end
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side companion to the gshare direction predictor.
- Buffers each in-flight prediction (PC, predicted direction/target, PHT index, history snapshot) in program order.
- When the execute stage resolves the oldest branch, compares outcome against prediction, emits a one-cycle predictor update, and on mispredict emits a redirect plus a flush of all younger in-flight predictions.
- Sits between fetch/predict and EX; also keeps saturating branch/mispredict statistics counters.

Parameters:
- DEPTH, 4, in-flight prediction entries (power of 2, >=2)
- PC_WIDTH, 64, PC/target width
- IDX_WIDTH, 8, PHT index width (matches predictor HASH_WIDTH)
- HIST_WIDTH, 8, branch history width (matches predictor BHT_WIDTH)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  fetch pushes a prediction
- pred_ready  out  1  queue can accept; equals (count != DEPTH)
- pred_pc  in  PC_WIDTH  branch PC
- pred_taken  in  1  predicted direction
- pred_target  in  PC_WIDTH  predicted target (meaningful when pred_taken)
- pred_idx  in  IDX_WIDTH  PHT index used for the prediction
- pred_hist  in  HIST_WIDTH  BHT history snapshot used
- res_valid  in  1  EX resolves the oldest branch this cycle
- res_taken  in  1  actual direction
- res_target  in  PC_WIDTH  actual taken target
- upd_valid  out  1  predictor update strobe
- upd_idx  out  IDX_WIDTH  PHT entry to train
- upd_taken  out  1  training direction
- upd_hist  out  HIST_WIDTH  new history = {pred_hist[HIST_WIDTH-2:0], res_taken}
- redirect_valid  out  1  mispredict; fetch must restart at redirect_pc
- redirect_pc  out  PC_WIDTH  corrected fetch PC
- res_error  out  1  res_valid arrived with queue empty
- branch_cnt  out  32  resolved branches, saturating
- miss_cnt  out  32  mispredicts, saturating

Behaviour:
- Reset: all outputs 0, count 0, head/tail pointers 0; pred_ready = 1 the cycle after reset deasserts. Reset mid-operation discards all entries and counters.
- Storage: circular FIFO; head/tail pointers of log2(DEPTH) bits wrapping naturally; count of log2(DEPTH)+1 bits.
- Push: pred_valid && pred_ready writes the entry at tail; tail+1.
- Pop: res_valid && count != 0 reads the head entry (combinationally, same cycle); head+1.
- Simultaneous push and pop (not full): count unchanged; entry written and entry read are distinct, or it is an empty queue where pop is illegal (res_error). No push/pop bypass.
- Full: pred_ready = 0; a pop in the same cycle does not raise pred_ready until the next cycle.
- mispredict = (res_taken != pred_taken) || (res_taken && res_target != pred_target).
- Correct PC = res_taken ? res_target : pred_pc + 4 (PC_WIDTH wrap-around arithmetic).
- Latency: all upd_*, redirect_*, res_error outputs registered; valid exactly one cycle after the resolving res_valid, 1-cycle pulses, otherwise 0. upd_* fields hold their last value when upd_valid = 0.
- Mispredict: the cycle of resolution also clears the queue (count 0, head = tail); a push in that same cycle is dropped (wrong path). redirect_valid pulses next cycle.
- Counters: branch_cnt +1 per valid pop; miss_cnt +1 per mispredict; both saturate at 0xFFFF_FFFF.
- res_error: res_valid with count = 0 → pulse next cycle; no update, no counter change, no redirect.

Decomposition:
- Shared defines (alongside the predictor's HASH/BHT widths): the IDX/HIST width constants and a PC_INC (= 4) constant.
- One natural sub-module, brq_fifo: a parameterised circular FIFO (entry = pc, taken, target, idx, hist) with push, pop, flush, full/empty and count.

Test Plan:
- Reset then push pc=0x8000_0000, taken=0, idx=0x12, hist=0x05; res_valid taken=0 → next cycle upd_valid=1, upd_idx=0x12, upd_taken=0, upd_hist=0x0A, redirect_valid=0, branch_cnt=1.
- Push pc=0x8000_0010, taken=0; resolve taken=1, target=0x8000_0100 → redirect_valid=1, redirect_pc=0x8000_0100, miss_cnt=1, queue empty.
- Push taken=1, target=0x8000_0200; resolve taken=0 → redirect_pc=pred_pc+4; predicted 0x8000_0300 resolving with target 0x8000_0304 → redirect_pc=0x8000_0304.
- Push 4 entries → pred_ready=0; 5th push ignored; pop and push in the same cycle at full → push still rejected, pred_ready=1 the next cycle; four correct pops return entries in push order.
- Mispredict with 3 younger entries queued and a concurrent push → all flushed, count=0, later res_valid raises res_error=1 and counters stay unchanged.
- Force miss_cnt to 0xFFFF_FFFF, then mispredict → stays 0xFFFF_FFFF. Assert reset mid-stream → all outputs 0 and count 0.
